alu_decoder_seq: RTL
====================

Name: alu_decoder_seq

Overview:
- Registered, parametrised ALU decoder for the single-cycle/multi-cycle RV32 cores.
- Decodes ALUOp/funct3/funct7 into a wide ALU control code covering full RV32I ALU ops plus the RV32M ops.
- Issues results through a one-entry valid/ready output stage and inserts a programmable busy interval for M-extension ops so the datapath can stall on multiply/divide.

Parameters:
- CTRL_W, 4, width of ALUControl_o; values below 4 are an elaboration error.
- EN_M, 1, 1 = RV32M decode enabled; 0 = M encodings are flagged illegal.
- MUL_LAT, 2, cycles from accept to valid_o for mul/mulh/mulhsu/mulhu; must be >= 1.
- DIV_LAT, 32, cycles from accept to valid_o for div/divu/rem/remu; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- valid_i  in  1  decode request valid.
- ready_o  out  1  block can accept a request this cycle.
- ALUOp  in  2  00 add, 01 sub, 10 funct-decoded, 11 lui/pass-B.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- funct7b0  in  1  instruction bit 25 (M-extension select).
- opb5  in  1  opcode bit 5 (1 = R-type).
- flush_i  in  1  drop in-flight and held requests.
- valid_o  out  1  ALUControl_o/mext_o/illegal_o valid.
- ready_i  in  1  consumer accepts output.
- ALUControl_o  out  CTRL_W  decoded control, zero-extended to CTRL_W.
- mext_o  out  1  1 = code is an M op (ALUControl_o = funct3).
- illegal_o  out  1  request was an unsupported encoding.
- busy_o  out  1  M-op interval counting.

Behaviour:
- Encoding (mext_o=0): ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.
- ALUOp 00 -> ADD; 01 -> SUB; 11 -> PASSB; funct inputs are ignored for all three.
- ALUOp 10, M op (opb5 & funct7b0): requires EN_M=1. Gives mext_o=1 and ALUControl_o={0,funct3}. funct3[2]=0 uses MUL_LAT, funct3[2]=1 uses DIV_LAT.
- ALUOp 10, non-M op, by funct3:
  - 000: SUB when opb5 & funct7b5, else ADD.
  - 001: SLL.
  - 010: SLT.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRA when funct7b5, else SRL.
  - 110: OR.
  - 111: AND.
- Illegal: M op with EN_M=0. Output is ADD, mext_o=0, illegal_o=1, with non-M latency.
- FSM states IDLE, COUNT, OUT; reset -> IDLE.
- ready_o = (state==IDLE) | (state==OUT & ready_i); combinational, never dependent on valid_i.
- Accept = valid_i & ready_o & !flush_i. Decoded fields are captured into output registers on accept.
- Non-M accept, or M accept with LAT=1: next state OUT, valid_o=1 the following cycle (latency 1).
- M accept with LAT>1: next state COUNT, counter loaded with LAT-2, busy_o=1.
  - COUNT decrements each cycle; at 0 -> OUT.
  - valid_o rises exactly LAT cycles after the accept edge.
- OUT holds valid_o and all output fields stable until ready_i=1.
  - On ready_i with accept: back-to-back issue to OUT/COUNT.
  - On ready_i without accept: -> IDLE.
- Counter width clog2(max(MUL_LAT,DIV_LAT)+1). No wrap: loads only on accept.
- flush_i (any state) -> IDLE next cycle, valid_o=0, busy_o=0, counter=0. Flush has priority over a same-cycle accept and over a same-cycle output handshake.
- Reset values: state IDLE, valid_o 0, busy_o 0, ALUControl_o 0, mext_o 0, illegal_o 0, counter 0; ready_o=1 in the first cycle after reset deasserts.
- Reset mid-COUNT or mid-OUT discards the request; no output is produced.
- busy_o=1 only in COUNT; valid_o=1 only in OUT.

Test Plan:
- Reset, then ALUOp=10, funct3=000, opb5=1, funct7b5=1, ready_i=1 -> one cycle later valid_o=1, ALUControl_o=1 (SUB), mext_o=0; ready_o stays 1 for a back-to-back ADD the next cycle.
- Sweep ALUOp=10 over all funct3, funct7b5∈{0,1}, opb5∈{0,1}, plus ALUOp 00/01/11 -> codes exactly per the table (e.g. funct3=101, funct7b5=1 -> 9; ALUOp=11 -> 10).
- EN_M=1, DIV_LAT=32: opb5=1, funct7b0=1, funct3=100 -> busy_o=1 for cycles 1..31, valid_o at cycle 32, ALUControl_o=4, mext_o=1, ready_o=0 throughout.
- Hold ready_i=0 for 5 cycles in OUT -> valid_o and fields stable, ready_o=0, new valid_i ignored. Then ready_i=1 with valid_i=1 -> handshake plus accept in the same cycle.
- flush_i asserted at cycle 10 of a DIV, and again during OUT concurrent with valid_i -> next cycle IDLE, valid_o=0, busy_o=0, flushed request never emerges, concurrent request not accepted.
- EN_M=0 with an M encoding -> valid_o after 1 cycle, ALUControl_o=0, mext_o=0, illegal_o=1. Also: reset asserted mid-COUNT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_decoder_seq.sv
// Registered RV32 ALU decoder with a one-entry valid/ready output stage.
// M-extension ops hold the request in a busy interval to let the datapath stall.
module alu_decoder_seq #(
  parameter int CTRL_W  = 4,
  parameter bit EN_M    = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic              opb5,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ALUControl_o,
  output logic              mext_o,
  output logic              illegal_o,
  output logic              busy_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam int MUL_LOAD_I = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int DIV_LOAD_I = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;
  localparam logic [CNT_W-1:0] MUL_LOAD = MUL_LOAD_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DIV_LOAD = DIV_LOAD_I[CNT_W-1:0];
  localparam bit MUL_LONG = (MUL_LAT > 1);
  localparam bit DIV_LONG = (DIV_LAT > 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;

  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_decoder_seq: CTRL_W must be at least 4");
  end
  if (MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
    $error("alu_decoder_seq: MUL_LAT and DIV_LAT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, COUNT, OUT} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CTRL_W-1:0] ctrl_q;
  logic              mext_q, illegal_q;
  logic [3:0]        dec_ctrl;
  logic              dec_mext, dec_illegal, dec_long;
  logic [CNT_W-1:0]  dec_load;
  logic              accept;

  always_comb begin
    dec_ctrl    = OP_ADD;
    dec_mext    = 1'b0;
    dec_illegal = 1'b0;
    unique case (ALUOp)
      2'b00: dec_ctrl = OP_ADD;
      2'b01: dec_ctrl = OP_SUB;
      2'b11: dec_ctrl = OP_PASSB;
      default: begin
        if (opb5 & funct7b0) begin
          if (EN_M) begin
            dec_mext = 1'b1;
            dec_ctrl = {1'b0, funct3};
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          unique case (funct3)
            3'b000: dec_ctrl = (opb5 & funct7b5) ? OP_SUB : OP_ADD;
            3'b001: dec_ctrl = OP_SLL;
            3'b010: dec_ctrl = OP_SLT;
            3'b011: dec_ctrl = OP_SLTU;
            3'b100: dec_ctrl = OP_XOR;
            3'b101: dec_ctrl = funct7b5 ? OP_SRA : OP_SRL;
            3'b110: dec_ctrl = OP_OR;
            default: dec_ctrl = OP_AND;
          endcase
        end
      end
    endcase
  end

  // funct3[2] separates the divide family from the multiply family
  assign dec_long = dec_mext & (funct3[2] ? DIV_LONG : MUL_LONG);
  assign dec_load = funct3[2] ? DIV_LOAD : MUL_LOAD;

  assign ready_o = (state == IDLE) | ((state == OUT) & ready_i);
  assign accept  = valid_i & ready_o & ~flush_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        COUNT: begin
          if (cnt == '0) state_n = OUT;
          else cnt_n = cnt - CNT_W'(1);
        end
        OUT: if (ready_i && !accept) state_n = IDLE;
        default: ;
      endcase
      if (accept) begin
        if (dec_long) begin
          state_n = COUNT;
          cnt_n   = dec_load;
        end else begin
          state_n = OUT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ctrl_q    <= '0;
      mext_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        ctrl_q    <= CTRL_W'(dec_ctrl);
        mext_q    <= dec_mext;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign valid_o      = (state == OUT);
  assign busy_o       = (state == COUNT);
  assign ALUControl_o = ctrl_q;
  assign mext_o       = mext_q;
  assign illegal_o    = illegal_q;

endmodule
